// File: rtl/sys_feed_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sys_feed_ctrl
// Description : Feed/collect controller for an N x N systolic array.
//               Accepts a job of inner length K, clears the PE accumulators,
//               streams K operand vectors from the A/B buffers into the array
//               with a per-lane diagonal skew, waits for the array to drain,
//               then buffers the N result rows in an N-entry FIFO and hands
//               them downstream under valid/ready.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   start_vld / start_rdy    : job request handshake (ready only when idle)
//   cfg_k                    : inner length K, captured at the handshake
//   a_/b_rd_en, _rd_addr     : operand buffer read strobe and step index
//   a_/b_rd_data             : operand vector, valid one cycle after rd_en
//   sys_a_/sys_b_vld, _data  : skewed per-lane operand feed into the array
//   pe_clr                   : one-cycle accumulator clear
//   c_in_vld, c_in_data      : result rows from the array (no backpressure)
//   res_vld/res_rdy/res_data : downstream result stream
//   done                     : one-cycle job-complete pulse
//   err_ovf                  : sticky result FIFO overflow
//   err_cfg                  : one-cycle pulse on an illegal cfg_k
// ============================================================================
module sys_feed_ctrl #(
    parameter int N      = 8,
    parameter int ES     = 8,
    parameter int KMAX   = 64,
    parameter int PE_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_vld,
    output logic                      start_rdy,
    input  logic [$clog2(KMAX):0]     cfg_k,
    output logic                      a_rd_en,
    output logic [$clog2(KMAX)-1:0]   a_rd_addr,
    input  logic [N*ES-1:0]           a_rd_data,
    output logic                      b_rd_en,
    output logic [$clog2(KMAX)-1:0]   b_rd_addr,
    input  logic [N*ES-1:0]           b_rd_data,
    output logic [N-1:0]              sys_a_vld,
    output logic [N*ES-1:0]           sys_a_data,
    output logic [N-1:0]              sys_b_vld,
    output logic [N*ES-1:0]           sys_b_data,
    output logic                      pe_clr,
    input  logic                      c_in_vld,
    input  logic [N*3*ES-1:0]         c_in_data,
    output logic                      res_vld,
    input  logic                      res_rdy,
    output logic [N*3*ES-1:0]         res_data,
    output logic                      done,
    output logic                      err_ovf,
    output logic                      err_cfg
);

    localparam int c_kw        = $clog2(KMAX) + 1;
    localparam int c_aw        = $clog2(KMAX);
    localparam int c_rw        = N * 3 * ES;
    localparam int c_cw        = $clog2(N + 1);
    localparam int c_pw        = (N > 1) ? $clog2(N) : 1;
    // Last operand needs N-1 skew cycles to reach the far lane, another N-1
    // to propagate across the array, plus the read latency and PE latency.
    localparam int c_drain_cyc = 2 * (N - 1) + 1 + PE_LAT;
    localparam int c_dw        = $clog2(c_drain_cyc + 1);

    localparam logic [c_kw-1:0] c_kmax       = c_kw'(KMAX);
    localparam logic [c_kw-1:0] c_k_one      = c_kw'(1);
    localparam logic [c_cw-1:0] c_n_full     = c_cw'(N);
    localparam logic [c_cw-1:0] c_cnt_one    = c_cw'(1);
    localparam logic [c_pw-1:0] c_ptr_last   = c_pw'(N - 1);
    localparam logic [c_pw-1:0] c_ptr_one    = c_pw'(1);
    localparam logic [c_dw-1:0] c_drain_last = c_dw'(c_drain_cyc - 1);
    localparam logic [c_dw-1:0] c_drain_one  = c_dw'(1);
    localparam logic [c_aw-1:0] c_addr_one   = c_aw'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLR     = 3'd1,
        FETCH   = 3'd2,
        DRAIN   = 3'd3,
        COLLECT = 3'd4,
        FLUSH   = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_kw-1:0]    r_k;
    logic [c_aw-1:0]    r_k_cnt;
    logic [c_dw-1:0]    r_drain_cnt;
    logic [c_cw-1:0]    r_row_cnt;
    logic               r_cfg_err;
    logic               r_rd_vld;

    logic [c_rw-1:0]    r_mem [N];
    logic [c_pw-1:0]    r_wr_ptr;
    logic [c_pw-1:0]    r_rd_ptr;
    logic [c_cw-1:0]    r_count;
    logic               r_err_ovf;

    logic               w_hs;
    logic               w_cfg_bad;
    logic               w_last_fetch;
    logic               w_push_req;
    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic               w_ovf;
    logic [c_cw-1:0]    w_rows_next;
    logic               w_flush_done;

    assign w_hs         = start_vld && (r_state == IDLE);
    assign w_cfg_bad    = (cfg_k == '0) || (cfg_k > c_kmax);
    assign w_last_fetch = ({1'b0, r_k_cnt} == (r_k - c_k_one));

    // Result FIFO control. A push into a full FIFO is still accepted when the
    // head leaves in the same cycle, so a full FIFO can stream at full rate.
    assign w_push_req = c_in_vld && (r_state != IDLE);
    assign w_pop      = (r_count != '0) && res_rdy;
    assign w_full     = (r_count == c_n_full);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf      = w_push_req && w_full && !w_pop;

    // Rows received this job, saturating at N (dropped rows still count).
    assign w_rows_next = (r_row_cnt == c_n_full) ? c_n_full
                                                 : r_row_cnt + c_cw'(w_push_req);

    function automatic logic [c_pw-1:0] f_ptr_inc(input logic [c_pw-1:0] p);
        return (p == c_ptr_last) ? '0 : p + c_ptr_one;
    endfunction

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_flush_done = 1'b0;
        start_rdy    = 1'b0;
        pe_clr       = 1'b0;
        a_rd_en      = 1'b0;
        b_rd_en      = 1'b0;
        a_rd_addr    = '0;
        b_rd_addr    = '0;
        case (r_state)
            IDLE: begin
                start_rdy = 1'b1;
                if (w_hs && !w_cfg_bad) begin
                    w_state_next = CLR;
                end
            end
            CLR: begin
                pe_clr       = 1'b1;
                w_state_next = FETCH;
            end
            FETCH: begin
                a_rd_en   = 1'b1;
                b_rd_en   = 1'b1;
                a_rd_addr = r_k_cnt;
                b_rd_addr = r_k_cnt;
                if (w_last_fetch) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == c_drain_last) begin
                    w_state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (w_rows_next == c_n_full) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (r_count == '0) begin
                    w_flush_done = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign done    = w_flush_done || r_cfg_err;
    assign err_cfg = r_cfg_err;
    assign err_ovf = r_err_ovf;
    assign res_vld = (r_count != '0);
    assign res_data = res_vld ? r_mem[r_rd_ptr] : '0;

    // ------------------------------------------------------------------
    // FSM state register and job counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_k_cnt     <= '0;
            r_drain_cnt <= '0;
            r_row_cnt   <= '0;
            r_cfg_err   <= 1'b0;
            r_rd_vld    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cfg_err <= w_hs && w_cfg_bad;
            r_rd_vld  <= (r_state == FETCH);

            if (w_hs) begin
                r_k <= cfg_k;
            end

            if (r_state == FETCH) begin
                r_k_cnt <= w_last_fetch ? '0 : r_k_cnt + c_addr_one;
            end else begin
                r_k_cnt <= '0;
            end

            if (r_state == DRAIN) begin
                r_drain_cnt <= r_drain_cnt + c_drain_one;
            end else begin
                r_drain_cnt <= '0;
            end

            r_row_cnt <= (r_state == IDLE) ? '0 : w_rows_next;
        end
    end

    // ------------------------------------------------------------------
    // Operand skew: lane r is delayed r cycles past the read latency, so
    // the far lane carries an N-1 deep shift register. Data is zeroed at
    // the entry of each chain whenever no read is returning.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < N; r++) begin : g_lane
        logic [ES-1:0] w_a_in;
        logic [ES-1:0] w_b_in;

        assign w_a_in = r_rd_vld ? a_rd_data[r*ES +: ES] : '0;
        assign w_b_in = r_rd_vld ? b_rd_data[r*ES +: ES] : '0;

        if (r == 0) begin : g_direct
            assign sys_a_vld[0]       = r_rd_vld;
            assign sys_b_vld[0]       = r_rd_vld;
            assign sys_a_data[0 +: ES] = w_a_in;
            assign sys_b_data[0 +: ES] = w_b_in;
        end else begin : g_skew
            logic [r-1:0]  r_vld_sr;
            logic [ES-1:0] r_a_sr [r];
            logic [ES-1:0] r_b_sr [r];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld_sr <= '0;
                    for (int i = 0; i < r; i++) begin
                        r_a_sr[i] <= '0;
                        r_b_sr[i] <= '0;
                    end
                end else begin
                    r_vld_sr[0] <= r_rd_vld;
                    r_a_sr[0]   <= w_a_in;
                    r_b_sr[0]   <= w_b_in;
                    for (int i = 1; i < r; i++) begin
                        r_vld_sr[i] <= r_vld_sr[i-1];
                        r_a_sr[i]   <= r_a_sr[i-1];
                        r_b_sr[i]   <= r_b_sr[i-1];
                    end
                end
            end

            assign sys_a_vld[r]         = r_vld_sr[r-1];
            assign sys_b_vld[r]         = r_vld_sr[r-1];
            assign sys_a_data[r*ES +: ES] = r_a_sr[r-1];
            assign sys_b_data[r*ES +: ES] = r_b_sr[r-1];
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= c_in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (w_ovf) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/sys_feed_ctrl.md
SYS_FEED_CTRL -- requirements
Module: sys_feed_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  N, 8, systolic array rows = columns
  ES, 8, operand element width
  KMAX, 64, maximum inner-dimension length
  PE_LAT, 1, PE multiply-accumulate latency in cycles
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  start_vld  in  1  job request
  start_rdy  out  1  controller accepts job
  cfg_k  in  clog2(KMAX)+1  inner length K, sampled at start handshake
  a_rd_en / b_rd_en  out  1  operand buffer read strobe
  a_rd_addr / b_rd_addr  out  clog2(KMAX)  operand step index k
  a_rd_data / b_rd_data  in  N*ES  operand vector, valid 1 cycle after rd_en
  sys_a_vld / sys_b_vld  out  N  per-lane feed valid to array
  sys_a_data / sys_b_data  out  N*ES  per-lane feed data to array
  pe_clr  out  1  accumulator clear pulse to array
  c_in_vld  in  1  array result row valid; no backpressure
  c_in_data  in  N*3*ES  array result row
  res_vld  out  1  result row valid downstream
  res_rdy  in  1  downstream ready
  res_data  out  N*3*ES  result row
  done  out  1  one-cycle job-complete pulse
  err_ovf  out  1  sticky result-buffer overflow
  err_cfg  out  1  one-cycle pulse on illegal cfg_k

Function
REQ-004 The FSM SHALL have states IDLE, CLR, FETCH, DRAIN, COLLECT and FLUSH.
REQ-005 start_rdy SHALL be 1 only in IDLE; start_vld with start_rdy high is the start handshake.
REQ-006 On handshake with cfg_k==0 or cfg_k>KMAX, the block SHALL pulse err_cfg and done in the next cycle and stay in IDLE.
REQ-007 On a legal handshake, the next state SHALL be CLR, with pe_clr=1 for exactly that one cycle.
REQ-008 In FETCH, a_rd_en and b_rd_en SHALL be 1 for exactly K consecutive cycles, with addr=0..K-1 incrementing by 1.
REQ-009 Skew: for the read issued at FETCH cycle k, lane r SHALL drive sys_a_data/sys_a_vld[r] and sys_b_data/sys_b_vld[r] at cycle k+1+r, with lane 0 unregistered beyond the read latency.
REQ-010 sys_*_vld[r] SHALL be 0 in every cycle that carries no skewed operand, and the matching sys_*_data lane SHALL then be 0.
REQ-011 The skew registers SHALL be N-1 deep per lane; no lane SHALL emit more than K valid beats per job.
REQ-012 DRAIN SHALL last exactly 2*(N-1)+1+PE_LAT cycles after the last FETCH cycle, then go to COLLECT.
REQ-013 The result buffer SHALL be an N-entry FIFO with a count of 0..N.
REQ-014 c_in_vld SHALL write into the FIFO in every non-IDLE state.
REQ-015 A write while count==N SHALL drop the row and set err_ovf; err_ovf clears only on rst.
REQ-016 res_vld SHALL equal (count!=0); a pop occurs on res_vld && res_rdy, head-first.
REQ-017 A simultaneous push and pop at count==N SHALL be legal and SHALL leave count unchanged, with no overflow.
REQ-018 The controller SHALL count received rows; on reaching N it SHALL go to FLUSH.
REQ-019 FLUSH SHALL wait for count==0, then pulse done and go to IDLE.
REQ-020 Job-to-job: a new handshake SHALL be possible the cycle after done.
REQ-021 FIFO pointers SHALL wrap modulo N.

Reset
REQ-022 On rst, all outputs SHALL be 0 except start_rdy=1; FSM=IDLE; FIFO empty; skew registers, counters and err_ovf cleared.
REQ-023 Reset asserted mid-job SHALL abort immediately, with no done pulse and no further rd_en.

Verification
REQ-024 cfg_k=4, N=8 -> pe_clr 1 cycle; 4 rd_en cycles addr 0..3; sys_a_vld[7] high in cycles 8..11 after the FETCH start; done after 8 rows are drained.
REQ-025 cfg_k=0 -> err_cfg and done one cycle later, no rd_en, start_rdy stays 1.
REQ-026 res_rdy=0 throughout, 9 c_in_vld rows -> count=8, err_ovf=1, 9th row dropped.
REQ-027 Count=8 with push and pop in the same cycle -> count stays 8, err_ovf=0, order preserved.
REQ-028 rst during FETCH at k=2 -> next cycle all outputs 0, start_rdy=1; a following cfg_k=1 job completes normally.
REQ-029 Back-to-back jobs, start_vld held high -> second handshake exactly one cycle after the first done.
